// File: rtl/ds1302_pkg.sv
// Shared DS1302 definitions: register addresses, command bit positions,
// reset values, FSM state encoding and a BCD increment helper.
package ds1302_pkg;

  // Clock-register addresses (command bits 5:1)
  localparam logic [2:0] ADDR_SEC   = 3'd0;
  localparam logic [2:0] ADDR_MIN   = 3'd1;
  localparam logic [2:0] ADDR_HOUR  = 3'd2;
  localparam logic [2:0] ADDR_DATE  = 3'd3;
  localparam logic [2:0] ADDR_MONTH = 3'd4;
  localparam logic [2:0] ADDR_WEEK  = 3'd5;
  localparam logic [2:0] ADDR_YEAR  = 3'd6;
  localparam logic [2:0] ADDR_WP    = 3'd7;

  // Command byte bit positions
  localparam int CMD_RD  = 0;
  localparam int CMD_RAM = 6;
  localparam int CMD_MSB = 7;

  // Register reset values: clock halted (CH=1), write protect set
  localparam logic [7:0] RST_SEC   = 8'h80;
  localparam logic [7:0] RST_MIN   = 8'h00;
  localparam logic [7:0] RST_HOUR  = 8'h00;
  localparam logic [7:0] RST_DATE  = 8'h01;
  localparam logic [7:0] RST_MONTH = 8'h01;
  localparam logic [7:0] RST_WEEK  = 8'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;
  localparam logic [7:0] RST_WP    = 8'h80;

  // Rollover points of the timekept registers (BCD)
  localparam logic [7:0] MAX_SEC  = 8'h59;
  localparam logic [7:0] MAX_MIN  = 8'h59;
  localparam logic [7:0] MAX_HOUR = 8'h23;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RDATA  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  // BCD increment with wrap; result bit 8 is the carry out. Anything at or
  // above the rollover point, and any invalid digit, wraps towards zero.
  function automatic logic [8:0] bcd_inc(input logic [7:0] value, input logic [7:0] max_value);
    logic [3:0] lo;
    logic [3:0] hi;
    logic [8:0] result;
    lo = value[3:0];
    hi = value[7:4];
    if (value >= max_value)
      result = {1'b1, 8'h00};
    else if (lo >= 4'd9)
      result = {1'b0, ((hi >= 4'd9) ? 4'd0 : hi + 4'd1), 4'd0};
    else
      result = {1'b0, hi, lo + 4'd1};
    return result;
  endfunction

endpackage

// File: rtl/ds1302_bcd_timekeeper.sv
// One-second divider plus BCD seconds/minutes/hours counters (24h).
// Host writes override the counters; a seconds write restarts the divider.
module ds1302_bcd_timekeeper
  import ds1302_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       ds1302_clk,
  input  logic       ds1302_rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] second,
  output logic [7:0] minute,
  output logic [7:0] hour
);

  logic       tick;
  logic       wr_sec;
  logic       wr_min;
  logic       wr_hour;
  logic       sec_run;
  logic [8:0] sec_inc;
  logic [8:0] min_inc;
  logic [8:0] hour_inc;

  assign wr_sec  = wr_en && (wr_addr == ADDR_SEC);
  assign wr_min  = wr_en && (wr_addr == ADDR_MIN);
  assign wr_hour = wr_en && (wr_addr == ADDR_HOUR);

  // CH (second[7]) halts counting; the divider keeps running regardless
  assign sec_run  = tick && !second[7];
  assign sec_inc  = bcd_inc({1'b0, second[6:0]}, MAX_SEC);
  assign min_inc  = bcd_inc(minute, MAX_MIN);
  assign hour_inc = bcd_inc(hour, MAX_HOUR);

  generate
    if (TICK_DIV > 0) begin : g_div
      localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
      localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
      logic [DW-1:0] div;

      // Free-running one-second divider, restarted by a seconds write
      always_ff @(posedge ds1302_clk or posedge ds1302_rst) begin
        if (ds1302_rst)
          div <= '0;
        else if (wr_sec || (div == DIV_LAST))
          div <= '0;
        else
          div <= div + 1'b1;
      end

      assign tick = (div == DIV_LAST);
    end else begin : g_nodiv
      assign tick = 1'b0;
    end
  endgenerate

  // Counter update: a host write beats the tick for that register, but carries
  // computed from the old values still ripple into registers not being written
  always_ff @(posedge ds1302_clk or posedge ds1302_rst) begin
    if (ds1302_rst) begin
      second <= RST_SEC;
      minute <= RST_MIN;
      hour   <= RST_HOUR;
    end else begin
      if (wr_sec)
        second <= wr_data;
      else if (sec_run)
        second <= sec_inc[7:0];

      if (wr_min)
        minute <= wr_data;
      else if (sec_run && sec_inc[8])
        minute <= min_inc[7:0];

      if (wr_hour)
        hour <= wr_data;
      else if (sec_run && sec_inc[8] && min_inc[8])
        hour <= {1'b0, hour_inc[6:0]};
    end
  end

endmodule

// File: rtl/ds1302_slave_emu.sv
// DS1302 device-side emulator: oversamples CE/SCLK/IO, decodes command
// bytes, serves reads/writes of the 8 clock registers and timekeeps in BCD.
module ds1302_slave_emu
  import ds1302_pkg::*;
#(
  parameter int TICK_DIV    = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       ds1302_clk,
  input  logic       ds1302_rst,
  input  logic       ds1302_ce,
  input  logic       ds1302_sclk,
  inout  wire        ds1302_io,
  output logic [7:0] reg_second,
  output logic [7:0] reg_minute,
  output logic [7:0] reg_hour,
  output logic [7:0] reg_date,
  output logic [7:0] reg_month,
  output logic [7:0] reg_week,
  output logic [7:0] reg_year,
  output logic [7:0] reg_wp,
  output logic       cmd_done,
  output logic       cmd_err
);

  // Synchronizer chain; bit 0 = CE, bit 1 = SCLK, bit 2 = IO
  logic [2:0] bus_in;
  logic [2:0] sync_stage [SYNC_STAGES];
  logic       ce_s;
  logic       sclk_s;
  logic       io_s;
  logic       ce_prev;
  logic       sclk_prev;
  logic       sclk_rise;
  logic       sclk_fall;

  state_t     state;
  logic [2:0] bitcnt;
  logic [3:0] fallcnt;
  logic [6:0] in_sr;
  logic [2:0] addr;
  logic [7:0] shift;
  logic       io_oe;
  logic       io_out;
  logic       wp_bit;

  logic [7:0] cmd_byte;
  logic [7:0] rd_value;
  logic       wr_hit;
  logic       wr_allowed;
  logic       wr_en;

  assign bus_in = {ds1302_io, ds1302_sclk, ds1302_ce};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First synchronizer stage samples the raw bus pins
        always_ff @(posedge ds1302_clk or posedge ds1302_rst) begin
          if (ds1302_rst) sync_stage[gi] <= '0;
          else            sync_stage[gi] <= bus_in;
        end
      end else begin : g_next
        // Later stages just retime the previous stage
        always_ff @(posedge ds1302_clk or posedge ds1302_rst) begin
          if (ds1302_rst) sync_stage[gi] <= '0;
          else            sync_stage[gi] <= sync_stage[gi-1];
        end
      end
    end
  endgenerate

  assign ce_s   = sync_stage[SYNC_STAGES-1][0];
  assign sclk_s = sync_stage[SYNC_STAGES-1][1];
  assign io_s   = sync_stage[SYNC_STAGES-1][2];

  // One extra flop on CE/SCLK for edge detection
  always_ff @(posedge ds1302_clk or posedge ds1302_rst) begin
    if (ds1302_rst) begin
      ce_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      ce_prev   <= ce_s;
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_rise = sclk_s && !sclk_prev;
  assign sclk_fall = !sclk_s && sclk_prev;

  // Byte as it stands on the 8th rise: seven shifted bits plus the live one
  assign cmd_byte = {io_s, in_sr};

  // Write commits on the 8th data rise; the WP register itself is always writable
  assign wr_hit     = ce_s && (state == ST_WDATA) && sclk_rise && (bitcnt == 3'd7);
  assign wr_allowed = (addr == ADDR_WP) || !wp_bit;
  assign wr_en      = wr_hit && wr_allowed;

  assign reg_wp = {wp_bit, 7'b0};

  // Register read mux, addressed by the command byte being decoded
  always_comb begin
    rd_value = '0;
    case (cmd_byte[3:1])
      ADDR_SEC:   rd_value = reg_second;
      ADDR_MIN:   rd_value = reg_minute;
      ADDR_HOUR:  rd_value = reg_hour;
      ADDR_DATE:  rd_value = reg_date;
      ADDR_MONTH: rd_value = reg_month;
      ADDR_WEEK:  rd_value = reg_week;
      ADDR_YEAR:  rd_value = reg_year;
      ADDR_WP:    rd_value = reg_wp;
      default:    rd_value = '0;
    endcase
  end

  ds1302_bcd_timekeeper #(
    .TICK_DIV (TICK_DIV)
  ) u_timekeeper (
    .ds1302_clk (ds1302_clk),
    .ds1302_rst (ds1302_rst),
    .wr_en      (wr_en),
    .wr_addr    (addr),
    .wr_data    (cmd_byte),
    .second     (reg_second),
    .minute     (reg_minute),
    .hour       (reg_hour)
  );

  // Non-timekept registers; only WP bit 7 is stored
  always_ff @(posedge ds1302_clk or posedge ds1302_rst) begin
    if (ds1302_rst) begin
      reg_date  <= RST_DATE;
      reg_month <= RST_MONTH;
      reg_week  <= RST_WEEK;
      reg_year  <= RST_YEAR;
      wp_bit    <= RST_WP[7];
    end else if (wr_en) begin
      case (addr)
        ADDR_DATE:  reg_date  <= cmd_byte;
        ADDR_MONTH: reg_month <= cmd_byte;
        ADDR_WEEK:  reg_week  <= cmd_byte;
        ADDR_YEAR:  reg_year  <= cmd_byte;
        ADDR_WP:    wp_bit    <= cmd_byte[7];
        default:    ;
      endcase
    end
  end

  // Bus protocol FSM; CE low overrides everything and aborts silently
  always_ff @(posedge ds1302_clk or posedge ds1302_rst) begin
    if (ds1302_rst) begin
      state    <= ST_IDLE;
      bitcnt   <= '0;
      fallcnt  <= '0;
      in_sr    <= '0;
      addr     <= '0;
      shift    <= '0;
      io_oe    <= 1'b0;
      io_out   <= 1'b0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      if (!ce_s) begin
        state  <= ST_IDLE;
        io_oe  <= 1'b0;
        bitcnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!ce_prev) begin
              state  <= ST_CMD;
              bitcnt <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              if (bitcnt == 3'd7) begin
                if (!cmd_byte[CMD_MSB] || cmd_byte[CMD_RAM] || (cmd_byte[5:4] != 2'b00)) begin
                  cmd_err <= 1'b1;
                  state   <= ST_IGNORE;
                end else if (cmd_byte[CMD_RD]) begin
                  shift   <= rd_value;
                  fallcnt <= '0;
                  state   <= ST_RDATA;
                end else begin
                  addr   <= cmd_byte[3:1];
                  bitcnt <= '0;
                  state  <= ST_WDATA;
                end
              end else begin
                in_sr  <= {io_s, in_sr[6:1]};
                bitcnt <= bitcnt + 3'd1;
              end
            end
          end
          ST_WDATA: begin
            if (sclk_rise) begin
              if (bitcnt == 3'd7) begin
                if (wr_allowed) cmd_done <= 1'b1;
                else            cmd_err  <= 1'b1;
                state <= ST_IGNORE;
              end else begin
                in_sr  <= {io_s, in_sr[6:1]};
                bitcnt <= bitcnt + 3'd1;
              end
            end
          end
          ST_RDATA: begin
            if (sclk_fall) begin
              if (fallcnt == 4'd8) begin
                io_oe    <= 1'b0;
                cmd_done <= 1'b1;
                state    <= ST_IGNORE;
              end else begin
                io_out  <= shift[0];
                shift   <= {1'b0, shift[7:1]};
                io_oe   <= 1'b1;
                fallcnt <= fallcnt + 4'd1;
              end
            end
          end
          ST_IGNORE: io_oe <= 1'b0;
          default: begin
            io_oe <= 1'b0;
            state <= ST_IGNORE;
          end
        endcase
      end
    end
  end

  assign ds1302_io = io_oe ? io_out : 1'bz;

endmodule

// File: tb/tb_ds1302_slave_emu.sv
// Bench for ds1302_slave_emu: a bus master drives two instances in lockstep,
// one without timekeeping (scoreboarded) and one with TICK_DIV=10.
// The IO nets carry a pull-up (untimed unit) and a pull-down (timed unit)
// so a released line is visible as the pull level.
module tb_ds1302_slave_emu;

  localparam int HALF = 6;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic ce      = 1'b0;
  logic sclk    = 1'b0;
  logic drv_oe  = 1'b0;
  logic drv_bit = 1'b0;
  wire  io_a;
  wire  io_b;

  logic [7:0] a_sec, a_min, a_hour, a_date, a_month, a_week, a_year, a_wp;
  logic       a_done, a_err;
  logic [7:0] b_sec, b_min, b_hour, b_date, b_month, b_week, b_year, b_wp;
  logic       b_done, b_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] m [8];
  logic [1:0] evt_q [$];
  logic       rd_q [$];

  assign io_a = drv_oe ? drv_bit : 1'bz;
  assign io_b = drv_oe ? drv_bit : 1'bz;
  pullup (io_a);
  pulldown (io_b);

  always #5 clk = ~clk;

  ds1302_slave_emu #(.TICK_DIV(0), .SYNC_STAGES(2)) dut (
    .ds1302_clk(clk), .ds1302_rst(rst), .ds1302_ce(ce), .ds1302_sclk(sclk), .ds1302_io(io_a),
    .reg_second(a_sec), .reg_minute(a_min), .reg_hour(a_hour), .reg_date(a_date),
    .reg_month(a_month), .reg_week(a_week), .reg_year(a_year), .reg_wp(a_wp),
    .cmd_done(a_done), .cmd_err(a_err)
  );

  ds1302_slave_emu #(.TICK_DIV(10), .SYNC_STAGES(2)) dut_tk (
    .ds1302_clk(clk), .ds1302_rst(rst), .ds1302_ce(ce), .ds1302_sclk(sclk), .ds1302_io(io_b),
    .reg_second(b_sec), .reg_minute(b_min), .reg_hour(b_hour), .reg_date(b_date),
    .reg_month(b_month), .reg_week(b_week), .reg_year(b_year), .reg_wp(b_wp),
    .cmd_done(b_done), .cmd_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m[0] = 8'h80; m[1] = 8'h00; m[2] = 8'h00; m[3] = 8'h01;
    m[4] = 8'h01; m[5] = 8'h01; m[6] = 8'h00; m[7] = 8'h80;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_sec"},   a_sec,   m[0]);
    check({tag, "_min"},   a_min,   m[1]);
    check({tag, "_hour"},  a_hour,  m[2]);
    check({tag, "_date"},  a_date,  m[3]);
    check({tag, "_month"}, a_month, m[4]);
    check({tag, "_week"},  a_week,  m[5]);
    check({tag, "_year"},  a_year,  m[6]);
    check({tag, "_wp"},    a_wp,    m[7]);
  endtask

  task automatic check_released(input string tag);
    check({tag, "_io_a"}, io_a, 1'b1);
    check({tag, "_io_b"}, io_b, 1'b0);
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; drv_oe = 1'b1; drv_bit = b[i];
      half();
      sclk = 1'b1;
      half();
    end
  endtask

  task automatic bus_end();
    sclk = 1'b0; drv_oe = 1'b0;
    half();
    ce = 1'b0;
    half(); half();
  endtask

  task automatic wr(input logic [7:0] c, input logic [7:0] d);
    logic [2:0] a;
    a = c[3:1];
    if (a == 3'd7 || !m[7][7]) begin
      evt_q.push_back(2'b01);
      m[a] = (a == 3'd7) ? (d & 8'h80) : d;
    end else begin
      evt_q.push_back(2'b10);
    end
    $display("write cmd=%02h data=%02h", c, d);
    ce = 1'b1; half();
    send_bits(c, 8);
    send_bits(d, 8);
    bus_end();
  endtask

  task automatic rd(input logic [7:0] c);
    logic [7:0] exp;
    exp = m[c[3:1]];
    for (int i = 0; i < 8; i++) rd_q.push_back(exp[i]);
    evt_q.push_back(2'b01);
    $display("read  cmd=%02h expect=%02h", c, exp);
    ce = 1'b1; half();
    send_bits(c, 8);
    drv_oe = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sclk = 1'b0; half();
      sclk = 1'b1; half();
      check($sformatf("rd%02h_bit%0d", c, k), io_a, rd_q.pop_front());
    end
    sclk = 1'b0; half();
    check_released($sformatf("rd%02h_after_fall9", c));
    ce = 1'b0; half(); half();
  endtask

  task automatic bad_cmd(input logic [7:0] c);
    evt_q.push_back(2'b10);
    $display("bad   cmd=%02h", c);
    ce = 1'b1; half();
    send_bits(c, 8);
    drv_oe = 1'b0;
    sclk = 1'b0; half();
    sclk = 1'b1; half();
    check_released($sformatf("bad%02h", c));
    bus_end();
  endtask

  task automatic abort_wr(input logic [7:0] c, input logic [7:0] d, input int nbits);
    $display("write cmd=%02h aborted after %0d data bits", c, nbits);
    ce = 1'b1; half();
    send_bits(c, 8);
    send_bits(d, nbits);
    sclk = 1'b0; drv_oe = 1'b0;
    half();
    ce = 1'b0;
    half(); half();
    check_released("abort");
  endtask

  task automatic reset_mid_read();
    $display("read  cmd=81 interrupted by reset after fall 4");
    ce = 1'b1; half();
    send_bits(8'h81, 8);
    drv_oe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b0; half();
      sclk = 1'b1; half();
    end
    check("pre_rst_bit3", io_a, 1'b0);
    rst = 1'b1;
    #1;
    check_released("rst_mid_read");
    ce = 1'b0; sclk = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_regs("rst_mid_read");
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_b_done(input string tag);
    int n;
    n = 0;
    while (!b_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, b_done, 1'b1);
  endtask

  task automatic tk_wrap();
    wait_b_done("tk_wrap_commit");
    repeat (8) @(negedge clk);
    check("tk_pre_sec",  b_sec,  8'h59);
    check("tk_pre_min",  b_min,  8'h59);
    check("tk_pre_hour", b_hour, 8'h23);
    repeat (3) @(negedge clk);
    check("tk_wrap_sec",  b_sec,  8'h00);
    check("tk_wrap_min",  b_min,  8'h00);
    check("tk_wrap_hour", b_hour, 8'h00);
  endtask

  task automatic tk_halt();
    wait_b_done("tk_halt_commit");
    check("tk_halt_sec0", b_sec, 8'h80);
    repeat (50) @(negedge clk);
    check("tk_halt_sec",  b_sec,  8'h80);
    check("tk_halt_min",  b_min,  8'h00);
    check("tk_halt_hour", b_hour, 8'h00);
  endtask

  // Pulse scoreboard for the untimed unit: every pulse must match the queue head
  always @(negedge clk) begin
    if (!rst && (a_done || a_err)) begin
      if (evt_q.size() == 0)
        check("evt_unexpected", {a_err, a_done}, 2'b00);
      else
        check("evt", {a_err, a_done}, evt_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    repeat (4) @(negedge clk);
    check_regs("reset");
    check_released("reset");
    check("reset_pulses", {a_err, a_done}, 2'b00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write protect blocks a year write, then lifted
    wr(8'h8C, 8'h24);
    check("year_blocked", a_year, 8'h00);
    wr(8'h8E, 8'h00);
    wr(8'h8C, 8'h24);
    check("year_written", a_year, 8'h24);

    // WP keeps only bit 7
    wr(8'h8E, 8'hFF);
    rd(8'h8F);
    wr(8'h8E, 8'h00);
    rd(8'h8F);

    // Seconds read-back and year read
    wr(8'h80, 8'h37);
    rd(8'h81);
    rd(8'h8D);

    // Aborted hour write, then a complete one
    abort_wr(8'h84, 8'h12, 4);
    check_regs("abort");
    wr(8'h84, 8'h12);
    check("hour_written", a_hour, 8'h12);

    // Unsupported commands
    bad_cmd(8'hC0);
    bad_cmd(8'hBE);
    bad_cmd(8'h00);
    check_regs("bad_cmds");

    // Reset in the middle of a read
    wr(8'h80, 8'h37);
    reset_mid_read();

    // Timekeeping rollover and halt on the timed unit
    wr(8'h8E, 8'h00);
    wr(8'h84, 8'h23);
    wr(8'h82, 8'h59);
    fork
      wr(8'h80, 8'h59);
      tk_wrap();
    join
    fork
      wr(8'h80, 8'h80);
      tk_halt();
    join

    check("evt_pending", evt_q.size(), 0);
    check_regs("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
